// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/ack bus between the MEM-stage controller and the data memory.
// The controller owns the request side (master); the memory returns read data and the ack.
interface mem_stage_ctrl_if;
  logic        DmemReq;
  logic        DmemWe;
  logic [31:0] DmemAddr;
  logic [3:0]  DmemByteEn;
  logic [31:0] DmemWData;
  logic [31:0] DmemRData;
  logic        DmemAck;

  modport master (
    output DmemReq, DmemWe, DmemAddr, DmemByteEn, DmemWData,
    input  DmemRData, DmemAck
  );

  modport slave (
    input  DmemReq, DmemWe, DmemAddr, DmemByteEn, DmemWData,
    output DmemRData, DmemAck
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage access controller: runs byte/half/word loads and stores against a
// variable-latency data memory and stalls the pipeline while an access is in flight.

// One byte lane of the store path: lane enable and the replicated store byte.
module mem_stage_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  sizeIn,
  input  logic [1:0]  addrLo,
  input  logic [31:0] storeData,
  output logic        byteEn,
  output logic [7:0]  wByte
);
  localparam logic [1:0] LaneIdx = 2'(LANE);

  always_comb begin
    byteEn = 1'b1;
    wByte  = storeData[8*LANE +: 8];
    case (sizeIn)
      2'b00: begin
        byteEn = (addrLo == LaneIdx);
        wByte  = storeData[7:0];
      end
      2'b01: begin
        byteEn = (addrLo[1] == LaneIdx[1]);
        wByte  = storeData[8*(LANE%2) +: 8];
      end
      default: ;
    endcase
  end
endmodule

module mem_stage_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              MemReadIn,
  input  logic              MemWriteIn,
  input  logic [1:0]        MemSizeIn,
  input  logic              LoadSignedIn,
  input  logic [31:0]       AddressIn,
  input  logic [31:0]       StoreDataIn,
  mem_stage_ctrl_if.master  dmem,
  output logic [31:0]       LoadDataOut,
  output logic              stall_EXMEM,
  output logic              stall_MEMWB,
  output logic              MisalignOut,
  output logic              BusErrOut
);
  localparam int NUM_LANES = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  logic [1:0]                  stateQ;
  logic [CNT_W-1:0]            cntQ;
  logic [31:0]                 addrQ;
  logic                        weQ;
  logic [NUM_LANES-1:0]        beQ;
  logic [31:0]                 wdataQ;
  logic [1:0]                  sizeQ;
  logic                        signQ;
  logic [1:0]                  aLoQ;
  logic [31:0]                 loadQ;

  logic                        access;
  logic                        misalign;
  logic                        accept;
  logic                        idleOn;
  logic                        busy;
  logic                        timeoutHit;
  logic [NUM_LANES-1:0]        laneBe;
  logic [NUM_LANES-1:0][7:0]   laneWb;

  // Load extraction from the returned word, using the access attributes
  // captured when the request was launched.
  function automatic logic [31:0] extractLoad(
    input logic [31:0] rd,
    input logic [1:0]  sz,
    input logic [1:0]  aLo,
    input logic        sgn
  );
    logic [7:0]  b;
    logic [15:0] h;
    case (aLo)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = aLo[1] ? rd[31:16] : rd[15:0];
    case (sz)
      2'b00:   extractLoad = {{24{sgn & b[7]}}, b};
      2'b01:   extractLoad = {{16{sgn & h[15]}}, h};
      default: extractLoad = rd;
    endcase
  endfunction

  assign access   = MemReadIn | MemWriteIn;
  assign misalign = ((MemSizeIn == 2'b01) & AddressIn[0]) |
                    (MemSizeIn[1] & (AddressIn[1:0] != 2'b00));
  assign accept   = access & ~misalign;

  // Reset also masks the Mealy outputs so everything reads 0 while Rst_n is low.
  assign idleOn     = Rst_n & (stateQ == IDLE);
  assign busy       = (stateQ == BUSY);
  assign timeoutHit = busy & ~dmem.DmemAck & (cntQ == CntLast);

  for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
    mem_stage_lane #(.LANE(i)) uLane (
      .sizeIn    (MemSizeIn),
      .addrLo    (AddressIn[1:0]),
      .storeData (StoreDataIn),
      .byteEn    (laneBe[i]),
      .wByte     (laneWb[i])
    );
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stateQ <= IDLE;
      cntQ   <= '0;
      addrQ  <= '0;
      weQ    <= 1'b0;
      beQ    <= '0;
      wdataQ <= '0;
      sizeQ  <= '0;
      signQ  <= 1'b0;
      aLoQ   <= '0;
      loadQ  <= '0;
    end else begin
      case (stateQ)
        IDLE: begin
          if (accept) begin
            stateQ <= BUSY;
            addrQ  <= {AddressIn[31:2], 2'b00};
            weQ    <= MemWriteIn;
            beQ    <= laneBe;
            wdataQ <= MemWriteIn ? laneWb : '0;
            sizeQ  <= MemSizeIn;
            signQ  <= LoadSignedIn;
            aLoQ   <= AddressIn[1:0];
            cntQ   <= '0;
          end
        end
        BUSY: begin
          cntQ <= cntQ + 1'b1;
          // Ack is checked first so a same-cycle ack beats the timeout.
          if (dmem.DmemAck) begin
            loadQ  <= weQ ? '0 : extractLoad(dmem.DmemRData, sizeQ, aLoQ, signQ);
            stateQ <= DONE;
          end else if (cntQ == CntLast) begin
            loadQ  <= '0;
            stateQ <= DONE;
          end
        end
        DONE: begin
          loadQ  <= '0;
          stateQ <= IDLE;
        end
        default: stateQ <= IDLE;
      endcase
    end
  end

  assign dmem.DmemReq    = busy;
  assign dmem.DmemWe     = busy & weQ;
  assign dmem.DmemAddr   = busy ? addrQ  : '0;
  assign dmem.DmemByteEn = busy ? beQ    : '0;
  assign dmem.DmemWData  = busy ? wdataQ : '0;

  assign LoadDataOut = loadQ;
  assign stall_EXMEM = busy | (idleOn & accept);
  assign stall_MEMWB = busy | (idleOn & access);
  assign MisalignOut = idleOn & access & misalign;
  assign BusErrOut   = timeoutHit;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: a default-timeout instance for normal
// traffic and a TIMEOUT=4 instance for the bus-error path.
module tb_mem_stage_ctrl;
  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] sd;
  } req_t;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  req_t in0 = '0;
  req_t in1 = '0;

  logic [31:0] ld0, ld1;
  logic stE0, stM0, mis0, err0;
  logic stE1, stM1, mis1, err1;

  int checks = 0;
  int failures = 0;
  logic [31:0] sbq[$];

  mem_stage_ctrl_if bus0();
  mem_stage_ctrl_if bus1();

  always #5 Clk = ~Clk;

  mem_stage_ctrl dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .MemReadIn(in0.rd), .MemWriteIn(in0.wr), .MemSizeIn(in0.sz),
    .LoadSignedIn(in0.sgn), .AddressIn(in0.addr), .StoreDataIn(in0.sd),
    .dmem(bus0), .LoadDataOut(ld0), .stall_EXMEM(stE0), .stall_MEMWB(stM0),
    .MisalignOut(mis0), .BusErrOut(err0)
  );

  mem_stage_ctrl #(.TIMEOUT(4), .CNT_W(8)) dutT (
    .Clk(Clk), .Rst_n(Rst_n),
    .MemReadIn(in1.rd), .MemWriteIn(in1.wr), .MemSizeIn(in1.sz),
    .LoadSignedIn(in1.sgn), .AddressIn(in1.addr), .StoreDataIn(in1.sd),
    .dmem(bus1), .LoadDataOut(ld1), .stall_EXMEM(stE1), .stall_MEMWB(stM1),
    .MisalignOut(mis1), .BusErrOut(err1)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one access on dut from IDLE to DONE; expected load goes through the scoreboard.
  task automatic run_access(input string nm, input logic rd, input logic wr,
                            input logic [1:0] sz, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] sd,
                            input logic [31:0] rdat, input int waitN,
                            input logic [3:0] expBe, input logic [31:0] expWd,
                            input logic [31:0] expLd, input int expStalls);
    int busyN = 0;
    int stallN = 0;
    bit done = 0;
    bit seenReq = 0;
    logic [31:0] e;
    sbq.push_back(expLd);
    in0 = '{rd, wr, sz, sgn, addr, sd};
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (bus0.DmemReq) busyN++;
      bus0.DmemAck   = bus0.DmemReq && (busyN == waitN + 1);
      bus0.DmemRData = bus0.DmemAck ? rdat : 32'h5A5A5A5A;
      @(negedge Clk);
      if (stE0) stallN++;
      if (cyc == 0) begin
        checks++;
        if (mis0 !== 1'b0 || stM0 !== 1'b1) begin
          failures++;
          $display("FAIL %s_launch: mis=%b stall_MEMWB=%b want 0/1", nm, mis0, stM0);
        end
      end
      if (bus0.DmemReq && !seenReq) begin
        seenReq = 1;
        checks++;
        if (bus0.DmemAddr !== {addr[31:2], 2'b00} || bus0.DmemByteEn !== expBe ||
            bus0.DmemWe !== wr) begin
          failures++;
          $display("FAIL %s_req: addr=%h be=%b we=%b want %h %b %b", nm, bus0.DmemAddr,
                   bus0.DmemByteEn, bus0.DmemWe, {addr[31:2], 2'b00}, expBe, wr);
        end
        if (wr) begin
          checks++;
          if (bus0.DmemWData !== expWd) begin
            failures++;
            $display("FAIL %s_wdata: got %h want %h", nm, bus0.DmemWData, expWd);
          end
        end
      end
      if (busyN > 0 && !bus0.DmemReq) begin
        done = 1;
        e = sbq.pop_front();
        checks++;
        if (ld0 !== e) begin
          failures++;
          $display("FAIL %s_load: got %h want %h", nm, ld0, e);
        end
        checks++;
        if (stE0 !== 1'b0 || stM0 !== 1'b0 || stallN != expStalls) begin
          failures++;
          $display("FAIL %s_stalls: done stalls=%b%b count=%0d want 00 %0d", nm, stE0, stM0,
                   stallN, expStalls);
        end
      end
      @(posedge Clk); #1;
    end
    bus0.DmemAck = 1'b0;
    in0 = '0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: access never reached DONE", nm);
      void'(sbq.pop_front());
    end
    @(negedge Clk);
    checks++;
    if (ld0 !== 32'h0 || stE0 !== 1'b0 || bus0.DmemReq !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle: load=%h stall=%b req=%b want 0 0 0", nm, ld0, stE0, bus0.DmemReq);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset;
    bus0.DmemAck = 1'b0; bus0.DmemRData = '0;
    bus1.DmemAck = 1'b0; bus1.DmemRData = '0;
    Rst_n = 1'b0;
    #3;
    checks++;
    if ({bus0.DmemReq, bus0.DmemWe, bus0.DmemAddr, bus0.DmemByteEn, bus0.DmemWData,
         ld0, stE0, stM0, mis0, err0} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: req=%b load=%h stalls=%b%b", bus0.DmemReq, ld0, stE0, stM0);
    end
    in0 = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0};
    #1;
    checks++;
    if (stE0 !== 1'b0 || stM0 !== 1'b0 || bus0.DmemReq !== 1'b0) begin
      failures++;
      $display("FAIL reset_masks_access: stalls=%b%b req=%b want 000", stE0, stM0, bus0.DmemReq);
    end
    in0 = '0;
    @(negedge Clk); Rst_n = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_lw;
    run_access("lw", 1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0,
               4'b1111, 32'h0, 32'hDEADBEEF, 2);
  endtask

  task automatic test_lb_delayed;
    run_access("lb_delay", 1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80112233, 5,
               4'b1000, 32'h0, 32'hFFFFFF80, 7);
  endtask

  task automatic test_stores;
    run_access("sh", 0, 1, 2'b01, 0, 32'h102, 32'h1234ABCD, 32'hFFFFFFFF, 0,
               4'b1100, 32'hABCDABCD, 32'h0, 2);
    run_access("sb", 0, 1, 2'b00, 0, 32'h101, 32'hAA551277, 32'h0, 1,
               4'b0010, 32'h77777777, 32'h0, 3);
    run_access("sw", 0, 1, 2'b10, 0, 32'h204, 32'hCAFEF00D, 32'h0, 2,
               4'b1111, 32'hCAFEF00D, 32'h0, 4);
    run_access("rd_wr", 1, 1, 2'b10, 0, 32'h208, 32'h01020304, 32'hFFFFFFFF, 0,
               4'b1111, 32'h01020304, 32'h0, 2);
  endtask

  task automatic test_loads;
    run_access("lhu", 1, 0, 2'b01, 0, 32'h102, 32'h0, 32'h80010000, 0,
               4'b1100, 32'h0, 32'h00008001, 2);
    run_access("lh", 1, 0, 2'b01, 1, 32'h102, 32'h0, 32'h80010000, 1,
               4'b1100, 32'h0, 32'hFFFF8001, 3);
    run_access("lh_pos", 1, 0, 2'b01, 1, 32'h100, 32'h0, 32'h80017FFF, 0,
               4'b0011, 32'h0, 32'h00007FFF, 2);
    run_access("lbu", 1, 0, 2'b00, 0, 32'h101, 32'h0, 32'h00009A00, 0,
               4'b0010, 32'h0, 32'h0000009A, 2);
    run_access("size11", 1, 0, 2'b11, 1, 32'h10C, 32'h0, 32'h13579BDF, 0,
               4'b1111, 32'h0, 32'h13579BDF, 2);
  endtask

  task automatic test_misalign;
    logic [1:0]  szT [4] = '{2'b10, 2'b01, 2'b10, 2'b11};
    logic [31:0] adT [4] = '{32'h101, 32'h103, 32'h102, 32'h101};
    for (int i = 0; i < 4; i++) begin
      in0 = '{1'b1, 1'b0, szT[i], 1'b0, adT[i], 32'h0};
      @(negedge Clk);
      checks++;
      if (bus0.DmemReq !== 1'b0 || mis0 !== 1'b1 || stM0 !== 1'b1 || stE0 !== 1'b0) begin
        failures++;
        $display("FAIL misalign_%0d: req=%b mis=%b stM=%b stE=%b want 0 1 1 0", i,
                 bus0.DmemReq, mis0, stM0, stE0);
      end
      @(posedge Clk); #1;
      in0 = '0;
      @(negedge Clk);
      checks++;
      if (bus0.DmemReq !== 1'b0 || mis0 !== 1'b0 || stM0 !== 1'b0) begin
        failures++;
        $display("FAIL misalign_after_%0d: req=%b mis=%b stM=%b want 000", i,
                 bus0.DmemReq, mis0, stM0);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_timeout;
    int busyN = 0;
    int errN = 0;
    int errAt = 0;
    bit done = 0;
    in1 = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0};
    for (int c = 0; c < 20 && !done; c++) begin
      if (bus1.DmemReq) busyN++;
      @(negedge Clk);
      if (err1) begin errN++; errAt = busyN; end
      if (busyN > 0 && !bus1.DmemReq) begin
        done = 1;
        checks++;
        if (ld1 !== 32'h0 || stE1 !== 1'b0 || stM1 !== 1'b0) begin
          failures++;
          $display("FAIL timeout_done: load=%h stalls=%b%b want 0 00", ld1, stE1, stM1);
        end
      end
      @(posedge Clk); #1;
    end
    in1 = '0;
    checks++;
    if (!done || errN != 1 || errAt != 4 || busyN != 4) begin
      failures++;
      $display("FAIL timeout_buserr: done=%b pulses=%0d at=%0d busy=%0d want 1 1 4 4",
               done, errN, errAt, busyN);
    end
    bus1.DmemAck = 1'b1; bus1.DmemRData = 32'hFFFFFFFF;
    @(negedge Clk);
    checks++;
    if (bus1.DmemReq !== 1'b0 || ld1 !== 32'h0 || err1 !== 1'b0) begin
      failures++;
      $display("FAIL late_ack: req=%b load=%h err=%b want 0 0 0", bus1.DmemReq, ld1, err1);
    end
    @(posedge Clk); #1;
    bus1.DmemAck = 1'b0;
    @(negedge Clk);
    checks++;
    if (bus1.DmemReq !== 1'b0 || ld1 !== 32'h0 || stE1 !== 1'b0) begin
      failures++;
      $display("FAIL late_ack_after: req=%b load=%h stall=%b want 0 0 0", bus1.DmemReq, ld1, stE1);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset_mid;
    in0 = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0};
    bus0.DmemAck = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    checks++;
    if (bus0.DmemReq !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_busy: req=%b want 1", bus0.DmemReq);
    end
    Rst_n = 1'b0;
    #1;
    checks++;
    if (bus0.DmemReq !== 1'b0 || stE0 !== 1'b0 || stM0 !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_drop: req=%b stalls=%b%b want 000", bus0.DmemReq, stE0, stM0);
    end
    in0 = '0;
    @(negedge Clk); Rst_n = 1'b1;
    @(posedge Clk); #1;
    @(negedge Clk);
    checks++;
    if (bus0.DmemReq !== 1'b0 || stE0 !== 1'b0 || ld0 !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_idle: req=%b stall=%b load=%h want 0 0 0", bus0.DmemReq, stE0, ld0);
    end
    @(posedge Clk); #1;
    run_access("lw_after_rst", 1, 0, 2'b10, 0, 32'h300, 32'h0, 32'h0BADF00D, 1,
               4'b1111, 32'h0, 32'h0BADF00D, 3);
  endtask

  // Random aligned loads; expected value built by shifting the returned word.
  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      logic [1:0]  sz;
      logic        sgn;
      logic [31:0] addr, rd, v, expLd;
      logic [3:0]  be;
      int          w;
      sz   = 2'($urandom_range(0, 2));
      sgn  = 1'($urandom_range(0, 1));
      rd   = $urandom;
      addr = $urandom & 32'h0000FFFC;
      if (sz == 2'b00) addr[1:0] = 2'($urandom_range(0, 3));
      if (sz == 2'b01) addr[1] = 1'($urandom_range(0, 1));
      w = $urandom_range(0, 3);
      v = rd >> (8 * addr[1:0]);
      if (sz == 2'b00) begin
        expLd = (sgn && v[7]) ? (v | 32'hFFFFFF00) : (v & 32'hFF);
        be = 4'b0001 << addr[1:0];
      end else if (sz == 2'b01) begin
        expLd = (sgn && v[15]) ? (v | 32'hFFFF0000) : (v & 32'hFFFF);
        be = addr[1] ? 4'b1100 : 4'b0011;
      end else begin
        expLd = rd;
        be = 4'b1111;
      end
      run_access("rand", 1, 0, sz, sgn, addr, 32'h0, rd, w, be, 32'h0, expLd, 2 + w);
    end
  endtask

  initial begin
    test_reset;
    test_lw;
    test_lb_delayed;
    test_stores;
    test_loads;
    test_misalign;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
